// File: rtl/switch_allocator.sv
// Round-robin switch allocator with per-output downstream credit counters and a registered ST stage.
// SWITCH_ALLOCATOR_ERR_CHECK_EN builds the sticky credit-overflow flag sa_err.

module switch_allocator_out #(
  parameter int NP    = 5,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NP-1:0] req_i,
  input  logic          credit_i,
  output logic [NP-1:0] gnt_o,
  output logic          avail_o,
  output logic [NP-1:0] st_ctrl_o,
  output logic          st_valid_o,
  output logic          ovf_o
);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NP-1:0] st_ctrl_q;
  logic          st_valid_q, has_cred, found;

  assign has_cred = (cnt_q != '0);

  // Scan from ptr_q upward, wrapping; first eligible requester wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    ptr_d = ptr_q;
    for (int k = 0; k < NP; k++) begin
      idx = PW'((int'(ptr_q) + k) % NP);
      if (!found && has_cred && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = (int'(idx) == NP - 1) ? '0 : idx + PW'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({found, credit_i})
      2'b10:   cnt_d = cnt_q - CW'(1);
      2'b01:   cnt_d = (cnt_q == FULL) ? FULL : cnt_q + CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      cnt_q      <= FULL;
      st_ctrl_q  <= '0;
      st_valid_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      st_ctrl_q  <= gnt_o;
      st_valid_q <= found;
    end
  end

  assign avail_o    = has_cred;
  assign st_ctrl_o  = st_ctrl_q;
  assign st_valid_o = st_valid_q;

`ifdef SWITCH_ALLOCATOR_ERR_CHECK_EN
  assign ovf_o = credit_i && (cnt_q == FULL);
`else
  assign ovf_o = 1'b0;
`endif
endmodule

module switch_allocator #(
  parameter int NUM_PORTS    = 5,
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           sa_request,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] sa_port,
  output logic [NUM_PORTS-1:0]           sa_grant,
  input  logic [NUM_PORTS-1:0]           credit_in,
  output logic [NUM_PORTS-1:0]           out_credit_avail,
  output logic [NUM_PORTS*NUM_PORTS-1:0] st_ctrl,
  output logic [NUM_PORTS-1:0]           st_valid,
  output logic                           sa_err
);
  localparam int NP = NUM_PORTS;

  logic [NP-1:0][NP-1:0] req;  // [output][input]
  logic [NP-1:0][NP-1:0] gnt;  // [output][input]
  logic [NP-1:0]         ovf;

  // Only an exact one-hot port selection is eligible; zero or multi-hot never matches.
  always_comb begin
    req = '0;
    for (int o = 0; o < NP; o++)
      for (int i = 0; i < NP; i++)
        req[o][i] = sa_request[i] && (sa_port[i*NP +: NP] == (NP'(1) << o));
  end

  always_comb begin
    sa_grant = '0;
    for (int i = 0; i < NP; i++)
      for (int o = 0; o < NP; o++)
        sa_grant[i] = sa_grant[i] | gnt[o][i];
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    switch_allocator_out #(.NP(NP), .DEPTH(CREDIT_DEPTH), .CW(CNT_WIDTH)) u_out (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req[o]),
      .credit_i   (credit_in[o]),
      .gnt_o      (gnt[o]),
      .avail_o    (out_credit_avail[o]),
      .st_ctrl_o  (st_ctrl[o*NP +: NP]),
      .st_valid_o (st_valid[o]),
      .ovf_o      (ovf[o])
    );
  end

`ifdef SWITCH_ALLOCATOR_ERR_CHECK_EN
  logic sa_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sa_err_q <= 1'b0;
    else if (|ovf) sa_err_q <= 1'b1;
  end
  assign sa_err = sa_err_q;

  always @(posedge clk) begin
    if (!rst)
      for (int o = 0; o < NP; o++)
        if (ovf[o]) $error("switch_allocator: credit overflow on output %0d", o);
  end
`else
  logic unused_ovf;
  assign unused_ovf = |ovf;
  assign sa_err     = 1'b0;
`endif
endmodule
